lsu_ctrl: RTL and testbench

- Load/store unit placed directly upstream of data_mem; the core issues byte/half/word requests over a valid/ready handshake.
- Generates word address, byte-lane write mask and lane-shifted write data for data_mem.
- Extracts and sign/zero-extends read data and returns a registered one-cycle response.
- Splits word-crossing misaligned accesses into two memory accesses, or flags them as errors when splitting is disabled.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_if.sv | 39 +++
 rtl/lsu_align.sv | 40 ++++
 rtl/lsu_ctrl.sv | 140 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared size encodings, FSM states and lane helpers for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } state_t;

    // The reserved size encoding behaves as a word everywhere.
    function automatic logic [3:0] bytemask(input logic [1:0] size);
        case (size)
            SZ_B:    bytemask = 4'b0001;
            SZ_H:    bytemask = 4'b0011;
            default: bytemask = 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SZ_B:    nbytes = 3'd1;
            SZ_H:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response handshake plus the data_mem port of the load/store unit.
interface lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    // The LSU sits in the middle, so the master side is the core plus data_mem.
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata, mem_rvalid,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_wmask, mem_ren, mem_wen
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata, mem_rvalid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_wmask, mem_ren, mem_wen
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store mask/data shifting and load merge with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  off,
    input  logic        phase,
    input  logic [31:0] wdata,
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata
);

    logic [5:0]  lo_sh;
    logic [5:0]  hi_sh;
    logic [2:0]  hi_lanes;
    logic [3:0]  bm;
    logic [31:0] merged;

    assign bm       = bytemask(size);
    assign lo_sh    = {1'b0, off, 3'b000};
    assign hi_sh    = 6'd32 - lo_sh;
    assign hi_lanes = 3'd4 - {1'b0, off};

    // A shift of 32 clears the high word, so aligned loads ignore hi_word.
    always_comb begin
        wmask      = phase ? (bm >> hi_lanes) : (bm << off);
        wdata_lane = phase ? (wdata >> hi_sh) : (wdata << lo_sh);
        merged     = (lo_word >> lo_sh) | (hi_word << hi_sh);
        case (size)
            SZ_B:    rdata = {{24{~uns & merged[7]}}, merged[7:0]};
            SZ_H:    rdata = {{16{~uns & merged[15]}}, merged[15:0]};
            default: rdata = merged;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit FSM: accepts core requests, drives data_mem for one or two
// word accesses and returns a registered single-cycle response.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1
) (
    input logic  clk,
    input logic  rst_n,
    lsu_if.slave bus
);

    state_t      state;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic        cross_q;
    logic [31:0] word0_q;

    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic [1:0]  req_off;
    logic        misaligned;
    logic        crossing;
    logic        in_acc;
    logic        phase1;
    logic        advance;
    logic [31:0] base;
    logic [31:0] lo_word;
    logic [31:0] hi_word;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    assign req_off    = bus.req_addr[1:0];
    assign misaligned = ((bus.req_size == SZ_H) && req_off[0]) ||
                        ((bus.req_size != SZ_B) && (bus.req_size != SZ_H) && (req_off != 2'b00));
    assign crossing   = ({1'b0, req_off} + nbytes(bus.req_size)) > 3'd4;

    assign in_acc  = (state == ACC0) || (state == ACC1);
    assign phase1  = (state == ACC1);
    assign advance = we_q | bus.mem_rvalid;
    assign base    = {addr_q[31:2], 2'b00};

    // In ACC1 the first word is already captured and memory supplies the high lanes.
    assign lo_word = phase1 ? word0_q : bus.mem_rdata;
    assign hi_word = phase1 ? bus.mem_rdata : 32'h0;

    lsu_align u_align (
        .size       (size_q),
        .uns        (uns_q),
        .off        (addr_q[1:0]),
        .phase      (phase1),
        .wdata      (wdata_q),
        .lo_word    (lo_word),
        .hi_word    (hi_word),
        .wmask      (lane_mask),
        .wdata_lane (lane_wdata),
        .rdata      (load_data)
    );

    // Decoded from state so an asynchronous reset kills a write immediately.
    assign bus.mem_addr  = !in_acc ? 32'h0 : (phase1 ? base + 32'd4 : base);
    assign bus.mem_wmask = in_acc ? lane_mask : 4'h0;
    assign bus.mem_wdata = in_acc ? lane_wdata : 32'h0;
    assign bus.mem_ren   = in_acc & ~we_q;
    assign bus.mem_wen   = in_acc & we_q;
    assign bus.req_ready = (state == IDLE);

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= 32'h0;
            size_q      <= SZ_B;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= 32'h0;
            cross_q     <= 1'b0;
            word0_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        size_q  <= bus.req_size;
                        we_q    <= bus.req_we;
                        uns_q   <= bus.req_unsigned;
                        wdata_q <= bus.req_wdata;
                        cross_q <= crossing;
                        word0_q <= 32'h0;
                        if (misaligned && !SPLIT_EN) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state <= ACC0;
                        end
                    end
                end
                ACC0: begin
                    if (advance) begin
                        word0_q <= bus.mem_rdata;
                        if (cross_q) begin
                            state <= ACC1;
                        end else begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= we_q ? 32'h0 : load_data;
                        end
                    end
                end
                ACC1: begin
                    if (advance) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= we_q ? 32'h0 : load_data;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: one splitting instance with a byte-lane memory
// model and one non-splitting instance backed by an address-derived read pattern.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if ifa ();
    lsu_if ifb ();

    lsu_ctrl #(.SPLIT_EN(1'b1)) dut_split (.clk(clk), .rst_n(rst_n), .bus(ifa));
    lsu_ctrl #(.SPLIT_EN(1'b0)) dut_nosplit (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mem_a [64];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx = 6'd0;
    logic [31:0] poke_data = 32'h0;
    logic        rv_en = 1'b1;

    assign ifa.mem_rdata  = mem_a[ifa.mem_addr[7:2]];
    assign ifa.mem_rvalid = ifa.mem_ren & rv_en;
    assign ifb.mem_rdata  = ~ifb.mem_addr;
    assign ifb.mem_rvalid = ifb.mem_ren;

    // Byte-lane data_mem model; the poke port preloads words independently of the DUT.
    always @(posedge clk) begin
        if (poke_en) begin
            mem_a[poke_idx] <= poke_data;
        end else if (ifa.mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (ifa.mem_wmask[b]) mem_a[ifa.mem_addr[7:2]][8*b +: 8] <= ifa.mem_wdata[8*b +: 8];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [5:0] idx, input logic [31:0] data);
        poke_en = 1'b1; poke_idx = idx; poke_data = data;
        tick();
        poke_en = 1'b0;
    endtask

    // Presents a request for one edge; returns sampled in the first cycle after acceptance.
    task automatic issue_a(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        ifa.req_we = we; ifa.req_size = size; ifa.req_unsigned = uns;
        ifa.req_addr = addr; ifa.req_wdata = wdata; ifa.req_valid = 1'b1;
        tick();
        ifa.req_valid = 1'b0;
    endtask

    task automatic issue_b(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        ifb.req_we = we; ifb.req_size = size; ifb.req_unsigned = uns;
        ifb.req_addr = addr; ifb.req_wdata = wdata; ifb.req_valid = 1'b1;
        tick();
        ifb.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_checks++; if (ifa.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid got %b want 0", ifa.rsp_valid); end
        n_checks++; if ({ifa.mem_ren, ifa.mem_wen, ifa.mem_wmask} !== 6'b0) begin n_fail++; $display("[TB] FAIL reset_mem_ctl got %b want 0", {ifa.mem_ren, ifa.mem_wen, ifa.mem_wmask}); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (ifa.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_ready got %b want 1", ifa.req_ready); end
        n_checks++; if (ifa.mem_addr !== 32'h0 || ifa.mem_wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mem_bus got addr %h wdata %h want 0", ifa.mem_addr, ifa.mem_wdata); end
        n_checks++; if (ifa.rsp_rdata !== 32'h0 || ifa.rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp got rdata %h err %b want 0", ifa.rsp_rdata, ifa.rsp_err); end
        n_checks++; if (ifb.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_ready_b got %b want 1", ifb.req_ready); end
    endtask

    task automatic test_store_byte();
        poke(6'd4, 32'h0);
        issue_a(1'b1, SZ_B, 1'b0, 32'h13, 32'h0000_00AB);
        n_checks++; if (ifa.mem_addr !== 32'h10) begin n_fail++; $display("[TB] FAIL sb_addr got %h want 00000010", ifa.mem_addr); end
        n_checks++; if (ifa.mem_wmask !== 4'b1000) begin n_fail++; $display("[TB] FAIL sb_wmask got %b want 1000", ifa.mem_wmask); end
        n_checks++; if (ifa.mem_wdata !== 32'hAB00_0000) begin n_fail++; $display("[TB] FAIL sb_wdata got %h want ab000000", ifa.mem_wdata); end
        n_checks++; if (ifa.mem_wen !== 1'b1 || ifa.mem_ren !== 1'b0 || ifa.req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_ctl got wen %b ren %b ready %b want 1 0 0", ifa.mem_wen, ifa.mem_ren, ifa.req_ready); end
        tick();
        n_checks++; if (ifa.rsp_valid !== 1'b1 || ifa.rsp_err !== 1'b0 || ifa.rsp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL sb_rsp got valid %b err %b rdata %h want 1 0 0", ifa.rsp_valid, ifa.rsp_err, ifa.rsp_rdata); end
        n_checks++; if (ifa.mem_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_wen_off got %b want 0", ifa.mem_wen); end
        tick();
        n_checks++; if (ifa.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_rsp_pulse got %b want 0", ifa.rsp_valid); end
        n_checks++; if (mem_a[4] !== 32'hAB00_0000) begin n_fail++; $display("[TB] FAIL sb_mem got %h want ab000000", mem_a[4]); end
    endtask

    task automatic test_load_ext();
        logic [1:0]  sz   [5] = '{SZ_B, SZ_B, SZ_H, SZ_H, SZ_W};
        logic        un   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] ad   [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
        logic [31:0] want [5] = '{32'hFFFF_FFAB, 32'h0000_00AB, 32'hFFFF_AB00, 32'h0000_AB00, 32'hAB00_0000};
        for (int i = 0; i < 5; i++) begin
            issue_a(1'b0, sz[i], un[i], ad[i], 32'h0);
            n_checks++; if (ifa.mem_ren !== 1'b1 || ifa.mem_addr !== 32'h10) begin n_fail++; $display("[TB] FAIL ld%0d_acc got ren %b addr %h want 1 00000010", i, ifa.mem_ren, ifa.mem_addr); end
            tick();
            n_checks++; if (ifa.rsp_valid !== 1'b1 || ifa.rsp_rdata !== want[i]) begin n_fail++; $display("[TB] FAIL ld%0d_rdata got valid %b rdata %h want 1 %h", i, ifa.rsp_valid, ifa.rsp_rdata, want[i]); end
            tick();
        end
    endtask

    task automatic test_split();
        poke(6'd8, 32'h4433_2211);
        poke(6'd9, 32'h8877_6655);
        issue_a(1'b0, SZ_W, 1'b0, 32'h21, 32'h0);
        n_checks++; if (ifa.mem_addr !== 32'h20) begin n_fail++; $display("[TB] FAIL lw_split_addr0 got %h want 00000020", ifa.mem_addr); end
        tick();
        n_checks++; if (ifa.mem_addr !== 32'h24 || ifa.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_split_addr1 got %h valid %b want 00000024 0", ifa.mem_addr, ifa.rsp_valid); end
        tick();
        n_checks++; if (ifa.rsp_valid !== 1'b1 || ifa.rsp_rdata !== 32'h5544_3322) begin n_fail++; $display("[TB] FAIL lw_split_rdata got valid %b rdata %h want 1 55443322", ifa.rsp_valid, ifa.rsp_rdata); end
        tick();
        issue_a(1'b1, SZ_W, 1'b0, 32'h23, 32'hDDCC_BBAA);
        n_checks++; if (ifa.mem_wmask !== 4'b1000 || ifa.mem_wdata !== 32'hAA00_0000) begin n_fail++; $display("[TB] FAIL sw_split_lo got mask %b wdata %h want 1000 aa000000", ifa.mem_wmask, ifa.mem_wdata); end
        tick();
        n_checks++; if (ifa.mem_wmask !== 4'b0111 || ifa.mem_wdata !== 32'h00DD_CCBB || ifa.mem_addr !== 32'h24) begin n_fail++; $display("[TB] FAIL sw_split_hi got mask %b wdata %h addr %h want 0111 00ddccbb 00000024", ifa.mem_wmask, ifa.mem_wdata, ifa.mem_addr); end
        tick();
        n_checks++; if (ifa.rsp_valid !== 1'b1 || ifa.rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_split_rsp got valid %b err %b want 1 0", ifa.rsp_valid, ifa.rsp_err); end
        tick();
        n_checks++; if (mem_a[8] !== 32'hAA33_2211 || mem_a[9] !== 32'h88DD_CCBB) begin n_fail++; $display("[TB] FAIL sw_split_mem got %h %h want aa332211 88ddccbb", mem_a[8], mem_a[9]); end
    endtask

    task automatic test_wrap();
        poke(6'd63, 32'h1122_3344);
        poke(6'd0, 32'h5566_7788);
        issue_a(1'b0, SZ_H, 1'b0, 32'hFFFF_FFFF, 32'h0);
        n_checks++; if (ifa.mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_addr0 got %h want fffffffc", ifa.mem_addr); end
        tick();
        n_checks++; if (ifa.mem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_addr1 got %h want 00000000", ifa.mem_addr); end
        tick();
        n_checks++; if (ifa.rsp_valid !== 1'b1 || ifa.rsp_rdata !== 32'hFFFF_8811) begin n_fail++; $display("[TB] FAIL wrap_rdata got valid %b rdata %h want 1 ffff8811", ifa.rsp_valid, ifa.rsp_rdata); end
        tick();
    endtask

    task automatic test_wait_state();
        rv_en = 1'b0;
        issue_a(1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
        tick();
        tick();
        n_checks++; if (ifa.mem_ren !== 1'b1 || ifa.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL wait_hold got ren %b valid %b want 1 0", ifa.mem_ren, ifa.rsp_valid); end
        rv_en = 1'b1;
        tick();
        n_checks++; if (ifa.rsp_valid !== 1'b1 || ifa.rsp_rdata !== 32'hAA33_2211) begin n_fail++; $display("[TB] FAIL wait_rdata got valid %b rdata %h want 1 aa332211", ifa.rsp_valid, ifa.rsp_rdata); end
        tick();
    endtask

    task automatic test_error();
        issue_b(1'b0, SZ_H, 1'b0, 32'h05, 32'h0);
        n_checks++; if (ifb.rsp_valid !== 1'b1 || ifb.rsp_err !== 1'b1 || ifb.rsp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL err_rsp got valid %b err %b rdata %h want 1 1 0", ifb.rsp_valid, ifb.rsp_err, ifb.rsp_rdata); end
        n_checks++; if (ifb.mem_ren !== 1'b0 || ifb.mem_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL err_mem got ren %b wen %b want 0 0", ifb.mem_ren, ifb.mem_wen); end
        tick();
        n_checks++; if (ifb.rsp_valid !== 1'b0 || ifb.mem_ren !== 1'b0 || ifb.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL err_after got valid %b ren %b ready %b want 0 0 1", ifb.rsp_valid, ifb.mem_ren, ifb.req_ready); end
        issue_b(1'b1, SZ_W, 1'b0, 32'h02, 32'h1234_5678);
        n_checks++; if (ifb.rsp_err !== 1'b1 || ifb.mem_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL err_sw got err %b wen %b want 1 0", ifb.rsp_err, ifb.mem_wen); end
        tick();
        issue_b(1'b0, SZ_W, 1'b0, 32'h40, 32'h0);
        tick();
        n_checks++; if (ifb.rsp_valid !== 1'b1 || ifb.rsp_err !== 1'b0 || ifb.rsp_rdata !== 32'hFFFF_FFBF) begin n_fail++; $display("[TB] FAIL nosplit_lw got valid %b err %b rdata %h want 1 0 ffffffbf", ifb.rsp_valid, ifb.rsp_err, ifb.rsp_rdata); end
        tick();
        issue_b(1'b0, SZ_B, 1'b1, 32'h41, 32'h0);
        tick();
        n_checks++; if (ifb.rsp_valid !== 1'b1 || ifb.rsp_rdata !== 32'h0000_00FF) begin n_fail++; $display("[TB] FAIL nosplit_lbu got valid %b rdata %h want 1 000000ff", ifb.rsp_valid, ifb.rsp_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        ifa.req_we = 1'b1; ifa.req_size = SZ_W; ifa.req_unsigned = 1'b0;
        ifa.req_addr = 32'h30; ifa.req_wdata = 32'h1234_5678; ifa.req_valid = 1'b1;
        tick();
        n_checks++; if (ifa.req_ready !== 1'b0 || ifa.mem_wen !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_n1 got ready %b wen %b want 0 1", ifa.req_ready, ifa.mem_wen); end
        ifa.req_we = 1'b0; ifa.req_wdata = 32'h0;
        tick();
        n_checks++; if (ifa.req_ready !== 1'b0 || ifa.rsp_valid !== 1'b1 || ifa.mem_ren !== 1'b0 || ifa.mem_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_n2 got ready %b valid %b ren %b wen %b want 0 1 0 0", ifa.req_ready, ifa.rsp_valid, ifa.mem_ren, ifa.mem_wen); end
        tick();
        n_checks++; if (ifa.req_ready !== 1'b1 || ifa.mem_ren !== 1'b0 || ifa.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_n3 got ready %b ren %b valid %b want 1 0 0", ifa.req_ready, ifa.mem_ren, ifa.rsp_valid); end
        tick();
        ifa.req_valid = 1'b0;
        n_checks++; if (ifa.mem_ren !== 1'b1 || ifa.mem_addr !== 32'h30) begin n_fail++; $display("[TB] FAIL b2b_second got ren %b addr %h want 1 00000030", ifa.mem_ren, ifa.mem_addr); end
        tick();
        n_checks++; if (ifa.rsp_valid !== 1'b1 || ifa.rsp_rdata !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL b2b_rdata got valid %b rdata %h want 1 12345678", ifa.rsp_valid, ifa.rsp_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic seen_rsp;
        poke(6'd10, 32'h0);
        poke(6'd11, 32'hCAFE_F00D);
        issue_a(1'b1, SZ_W, 1'b0, 32'h2B, 32'hDDCC_BBAA);
        tick();
        n_checks++; if (ifa.mem_wen !== 1'b1 || ifa.mem_addr !== 32'h2C) begin n_fail++; $display("[TB] FAIL rstmid_acc1 got wen %b addr %h want 1 0000002c", ifa.mem_wen, ifa.mem_addr); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (ifa.mem_wen !== 1'b0 || ifa.mem_wmask !== 4'h0) begin n_fail++; $display("[TB] FAIL rstmid_wen got wen %b mask %b want 0 0000", ifa.mem_wen, ifa.mem_wmask); end
        tick();
        tick();
        rst_n = 1'b1;
        seen_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen_rsp |= ifa.rsp_valid;
        end
        n_checks++; if (seen_rsp !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_no_rsp got %b want 0", seen_rsp); end
        n_checks++; if (mem_a[11] !== 32'hCAFE_F00D || mem_a[10] !== 32'hAA00_0000) begin n_fail++; $display("[TB] FAIL rstmid_mem got %h %h want aa000000 cafef00d", mem_a[10], mem_a[11]); end
        n_checks++; if (ifa.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_ready got %b want 1", ifa.req_ready); end
    endtask

    initial begin
        ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_size = SZ_B; ifa.req_unsigned = 1'b0;
        ifa.req_addr = 32'h0; ifa.req_wdata = 32'h0;
        ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_size = SZ_B; ifb.req_unsigned = 1'b0;
        ifb.req_addr = 32'h0; ifb.req_wdata = 32'h0;
        test_reset();
        test_store_byte();
        test_load_ext();
        test_split();
        test_wrap();
        test_wait_state();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
